// File: rtl/sar_out_pack.sv
// -----------------------------------------------------------------------------
// sar_out_pack
//
// Back-end stage behind the SAR core. Once per sampling clock it takes one SAR
// result. If a conversion did not complete in time, the last good code is used
// instead and the event is flagged and counted. Every PACK samples are packed
// into one wide word. Words are queued in a small FIFO that is read through a
// valid/ready interface.
//
// Optional build macro: SAR_OUT_OFFSET_EN
//   When defined, an extra signed "offset" input is present. Each complete code
//   becomes (code - offset), saturated to [0, 2^ADC_BITS-1]. The held code
//   stores this corrected value.
//
// Ports:
//   clk            sampling clock (rising edge)
//   rst            synchronous active-high reset
//   en             capture enable; low discards the partial word
//   adc_data       SAR code, index 0 = MSB
//   compl          conversion-complete flag for this sample
//   offset         (SAR_OUT_OFFSET_EN only) signed offset subtracted from codes
//   out_data       FIFO head word, lane 0 (oldest sample) in the low bits
//   out_valid      FIFO non-empty
//   out_ready      consumer accepts the head word at a clk edge
//   overflow       sticky: a completed word was dropped because the FIFO was full
//   incomplete     one-cycle pulse after an incomplete capture
//   incomplete_cnt saturating count of incomplete captures
// -----------------------------------------------------------------------------
module sar_out_pack #(
    parameter int ADC_BITS   = 8,
    parameter int PACK       = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int ERR_CNT_W  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [0:ADC_BITS-1]          adc_data,
    input  logic                         compl,
`ifdef SAR_OUT_OFFSET_EN
    input  logic signed [ADC_BITS:0]     offset,
`endif
    output logic [PACK*ADC_BITS-1:0]     out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         overflow,
    output logic                         incomplete,
    output logic [ERR_CNT_W-1:0]         incomplete_cnt
);

    localparam int IDX_W  = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FCNT_W = PTR_W + 1;
    localparam int WORD_W = PACK * ADC_BITS;

    // ---------------------------------------------------------------- capture
    logic [ADC_BITS-1:0] raw_code;
    logic [ADC_BITS-1:0] corr_code;
    logic [ADC_BITS-1:0] sample_code;

    // The SAR core delivers the MSB at index 0. Reverse it into a normal binary code.
    generate
        for (genvar gi = 0; gi < ADC_BITS; gi++) begin : g_bit_rev
            assign raw_code[ADC_BITS-1-gi] = adc_data[gi];
        end
    endgenerate

`ifdef SAR_OUT_OFFSET_EN
    // Two extra bits hold the full range of (code - offset), which is -255..511
    // for ADC_BITS=8. The top bit is the sign. The next bit shows the result is
    // above full scale.
    logic signed [ADC_BITS+1:0] diff;
    assign diff = $signed({2'b00, raw_code}) - $signed({offset[ADC_BITS], offset});

    always_comb begin
        corr_code = diff[ADC_BITS-1:0];
        if (diff[ADC_BITS+1]) begin
            corr_code = '0;
        end else if (diff[ADC_BITS]) begin
            corr_code = '1;
        end
    end
`else
    assign corr_code = raw_code;
`endif

    logic [ADC_BITS-1:0] held_reg;
    assign sample_code = compl ? corr_code : held_reg;

    // ---------------------------------------------------------------- packing
    logic [IDX_W-1:0]    lane_idx_reg;
    logic [ADC_BITS-1:0] lanes_reg [2**IDX_W];
    logic [WORD_W-1:0]   word_next;
    logic                last_lane;

    assign last_lane = (lane_idx_reg == IDX_W'(PACK - 1));

    // A word is pushed on the edge that captures its last lane. That lane comes
    // straight from the current sample. The earlier lanes come from registers.
    generate
        for (genvar gi = 0; gi < PACK; gi++) begin : g_word
            if (gi == PACK - 1) begin : g_cur
                assign word_next[gi*ADC_BITS +: ADC_BITS] = sample_code;
            end else begin : g_old
                assign word_next[gi*ADC_BITS +: ADC_BITS] = lanes_reg[gi];
            end
        end
    endgenerate

    // ---------------------------------------------------------------- FIFO
    logic [WORD_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [FCNT_W-1:0] fifo_cnt_reg;
    logic              push;
    logic              pop;
    logic              full;
    logic              do_write;

    assign push     = en && last_lane;
    assign out_valid = (fifo_cnt_reg != '0);
    assign pop      = out_valid && out_ready;
    assign full     = (fifo_cnt_reg == FCNT_W'(FIFO_DEPTH));
    // When the FIFO is full, a pop on the same edge frees the head slot. The
    // head is read before the edge, so the new word can take that slot.
    assign do_write = push && (!full || pop);

    assign out_data = out_valid ? fifo_mem[rd_ptr_reg] : '0;

    // Storage has no reset. Reset only clears the pointers and the count.
    always_ff @(posedge clk) begin
        if (do_write) begin
            fifo_mem[wr_ptr_reg] <= word_next;
        end
    end

    logic                 overflow_reg;
    logic                 incomplete_reg;
    logic [ERR_CNT_W-1:0] incomplete_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            lane_idx_reg       <= '0;
            held_reg           <= '0;
            for (int i = 0; i < 2**IDX_W; i++) begin
                lanes_reg[i] <= '0;
            end
            wr_ptr_reg         <= '0;
            rd_ptr_reg         <= '0;
            fifo_cnt_reg       <= '0;
            overflow_reg       <= 1'b0;
            incomplete_reg     <= 1'b0;
            incomplete_cnt_reg <= '0;
        end else begin
            incomplete_reg <= en && !compl;

            if (en) begin
                if (compl) begin
                    held_reg <= corr_code;
                end else if (incomplete_cnt_reg != '1) begin
                    incomplete_cnt_reg <= incomplete_cnt_reg + ERR_CNT_W'(1);
                end
                lanes_reg[lane_idx_reg] <= sample_code;
                lane_idx_reg <= last_lane ? '0 : lane_idx_reg + IDX_W'(1);
            end else begin
                lane_idx_reg <= '0;
            end

            if (push && full && !pop) begin
                overflow_reg <= 1'b1;
            end

            if (do_write) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            if (do_write && !pop) begin
                fifo_cnt_reg <= fifo_cnt_reg + FCNT_W'(1);
            end else if (pop && !do_write) begin
                fifo_cnt_reg <= fifo_cnt_reg - FCNT_W'(1);
            end
        end
    end

    assign overflow       = overflow_reg;
    assign incomplete     = incomplete_reg;
    assign incomplete_cnt = incomplete_cnt_reg;

endmodule

// File: doc/sar_out_pack.md
Name: sar_out_pack

Overview:
- Digital back-end stage directly downstream of the SAR core (DAC, async clock gen, SAR logic).
- Once per sampling clock, takes the SAR result (adc_data) and conversion-complete flag (compl).
- Flags and substitutes incomplete conversions, packs PACK consecutive codes into one wide word, and buffers words in a small FIFO behind a valid/ready interface to the chip's digital side.

Parameters:
- ADC_BITS, 8, resolution; must match the SAR core.
- PACK, 4, samples per output word (>=1).
- FIFO_DEPTH, 4, output FIFO entries (power of 2, >=2).
- ERR_CNT_W, 16, width of the incomplete-conversion counter.

Ports:
- clk  in  1  sampling clock; same clock that starts SAR conversions.
- rst  in  1  synchronous, active-high reset.
- en  in  1  capture enable.
- adc_data  in  [0:ADC_BITS-1]  SAR code; index 0 = MSB.
- compl  in  1  conversion complete; high before the next clk rising edge when the conversion finished.
- out_data  out  [PACK*ADC_BITS-1:0]  FIFO head word; lane 0 (oldest sample) in bits [ADC_BITS-1:0].
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts the word when valid & ready at a clk edge.
- overflow  out  1  sticky: a word was dropped.
- incomplete  out  1  one-cycle pulse: the last capture was incomplete.
- incomplete_cnt  out  [ERR_CNT_W-1:0]  saturating count of incomplete captures.

Behaviour:
- Clock and reset: single clock clk, rising edge only; reset rst is synchronous, active-high.
- Reset values: out_valid=0, overflow=0, incomplete=0, incomplete_cnt=0, lane index=0, held code=0, FIFO empty, out_data=0.
- Capture: at each rising clk edge with en=1, one sample is taken.
  - Code conversion: lane bit [ADC_BITS-1-i] = adc_data[i], i.e. MSB-first to binary.
- Incomplete conversion (compl=0 at capture):
  - Substitute the held code (last valid captured code, 0 after reset).
  - incomplete=1 in the following cycle.
  - incomplete_cnt +1, saturating at all-ones.
  - Held code is not updated.
- Complete conversion (compl=1): code is captured and the held code is updated.
- Packing:
  - Lane index counts 0..PACK-1.
  - The sample at index PACK-1 completes a word; the word (previous lanes plus current sample) is pushed into the FIFO at that same edge and the index wraps to 0.
  - Latency: the word is visible with out_valid=1 in the cycle after the edge that captured its last sample.
- en=0: no capture, no count. The partial word is discarded and the lane index returns to 0 at the first edge with en=0.
- FIFO:
  - Pop at an edge where out_valid & out_ready.
  - out_data and out_valid hold stable while out_valid & !out_ready.
  - Push while full with no pop: the new word is dropped, overflow is set and stays set until rst.
  - Push and pop in the same edge while full: both occur, no overflow.
  - Push and pop in the same edge while empty: the word enters the FIFO. The pop is ignored because out_valid=0.
- Reset mid-operation: partial word, FIFO contents, counters and flags are all cleared. Capture restarts at lane 0 on the first edge after rst deasserts.
- PACK=1: every capture pushes a word.

Optional Feature:
- Macro: SAR_OUT_OFFSET_EN.
- Defined:
  - Adds input port offset, signed [ADC_BITS:0].
  - Each complete code is corrected as code - offset, saturated to [0, 2^ADC_BITS-1], before packing.
  - The held code stores the corrected value; incomplete substitution reuses it uncorrected-again.
- Undefined: no offset port; codes pass through unchanged.

Test Plan:
- Basic pack (ADC_BITS=8, PACK=4, ready=1): compl=1 with adc_data giving codes 0x11,0x22,0x33,0x44 on 4 edges -> one cycle later out_valid=1, out_data=0x44332211; no incomplete, count 0.
- Bit order: adc_data[0]=1, others 0 -> lane code 0x80.
- Incomplete: codes 0x10, then compl=0, then 0x30, 0x40 -> word 0x40301010; incomplete pulses once; incomplete_cnt=1. Repeat 70000 incomplete captures with ERR_CNT_W=16 -> counter stays 0xFFFF.
- Backpressure/overflow (FIFO_DEPTH=4, ready=0): capture 20 samples -> 4 words held, 5th dropped, overflow=1 sticky. Set ready=1 -> the first 4 words drain in order, out_data stable during the stall. Full with simultaneous push+pop -> no overflow.
- en/reset mid-word: 2 samples, en=0 for 1 cycle, then 4 samples -> the only word is the last 4 samples. rst asserted with 3 words queued -> next cycle out_valid=0, overflow=0, count=0.
- SAR_OUT_OFFSET_EN: offset=+5 with code 0x03 -> 0x00; offset=-10 with code 0xFA -> 0xFF; offset=+5 with code 0x80 -> 0x7B.
